cpu_instruction_cache: RTL and testbench
========================================

Name: cpu_instruction_cache

Overview:
Direct-mapped instruction cache: the responder side of the CPU pipeline's instruction-fetch interface. It returns one instruction word plus its word address per request on `cache_line`, and asserts `cache_miss` when the word is not resident. On a miss it fetches an aligned burst of words from the memory arbiter and then resumes serving hits. It sits between the CPU pipeline and the memory controller's instruction read port.

Parameters:
- INDEX_BITS, 8, log2 of entry count (256 entries, one 16-bit word each).
- ADDRESS_BITS, 15, word address width (byte address bits [15:1]).
- FILL_WORDS_LOG2, 2, log2 of words fetched per miss (4-word aligned burst).

Ports:
- CLK  input  1  clock.
- RSTb  input  1  reset.
- cache_request_address  input  15  word address requested by the pipeline (its PC).
- cache_line  output  32  [31:17] word address of returned instruction, [16] valid, [15:0] instruction.
- cache_miss  output  1  1 = cache_line does not hold the previously requested address.
- invalidate  input  1  single-cycle pulse: flush all entries.
- mem_address  output  15  word address of current fill word.
- mem_rd_req  output  1  fill request to memory arbiter.
- mem_rd_ready  input  1  arbiter grant; burst starts.
- mem_data  input  16  fill data.
- mem_data_valid  input  1  mem_data valid this cycle; one word per assertion, in ascending address order.

Behaviour:
- Reset: RSTb, synchronous, active-low; clock CLK. Reset forces st_flush with entry counter = 0; mem_rd_req = 0; cache_line = 0; cache_miss = 1.
- Address split: index = addr[INDEX_BITS-1:0]; tag = addr[14:INDEX_BITS] (7 bits). Entry storage = {valid, tag[6:0], data[15:0]} = 24 bits.
- Latency: synchronous read, 1 cycle.
  - addr_r <= cache_request_address every cycle.
  - cache_line = {addr_r, entry.valid, entry.data}, from the registered RAM output.
- Hit rule: hit = (state == st_idle) && entry.valid && (entry.tag == addr_r tag). cache_miss = ~hit; this is combinational from the RAM output and addr_r. The miss therefore refers to the address presented in the previous cycle, matching the pipeline's PC rewind.
- FSM states: st_flush, st_idle, st_request, st_fill.
  - st_flush: write valid = 0 to entry[cnt] and increment cnt each cycle. After entry 2^INDEX_BITS-1 go to st_idle. cache_miss = 1 throughout; takes 256 cycles.
  - st_idle:
    - On miss (valid clear or tag mismatch): latch fill_base = {addr_r[14:2], 2'b00}, clear the word counter, go to st_request.
    - If invalidate is pulsed, go to st_flush; invalidate takes priority over a miss.
  - st_request: mem_rd_req = 1, mem_address = fill_base. Hold until mem_rd_ready = 1, then go to st_fill.
  - st_fill:
    - mem_rd_req stays 1 and mem_address = fill_base + word_cnt.
    - Each mem_data_valid writes {1, tag, mem_data} to index (fill_base + word_cnt), then word_cnt increments.
    - After 2^FILL_WORDS_LOG2 words, drop mem_rd_req and go to st_idle.
- Boundary conditions:
  - Requests during fill: request-address changes are ignored; cache_miss stays 1 in every non-idle state.
  - invalidate during st_request/st_fill: latched into a pending flag. The burst is never aborted; go to st_flush after the fill completes. The pending flag clears on entering st_flush.
  - invalidate during st_flush: restart cnt at 0.
  - Wrap-around: fill_base + word_cnt never carries out of the aligned block. Address 0x7FFF fills 0x7FFC..0x7FFF.
  - RAM read/write collision on the same index: read returns old data. No bypass is needed because miss is forced outside st_idle.
  - Reset mid-fill: immediately go to st_flush; mem_rd_req = 0 on the next cycle. Any remaining mem_data_valid pulses are ignored.
  - First st_idle cycle after fill: RAM output is stale, so the result may be a miss. Re-evaluation on the next request is correct; no extra fill occurs because a stale miss only re-fills if the tag still mismatches.

Decomposition:
- cpu_defs.v gets:
  - cache_line field positions (ADDR 31:17, VALID 16, INS 15:0);
  - cache FSM state localparams.
- Sub-module cpu_icache_ram: 2^INDEX_BITS x 24 simple dual-port BRAM, one synchronous read port and one write port, no reset. This is the only natural split.

Test Plan:
- Reset: hold RSTb = 0 for 2 cycles, then release -> cache_miss = 1 and mem_rd_req = 0 for 256 cycles; after that, request 0x0000 -> miss, mem_address = 0x0000.
- Cold miss: request 0x0123; grant after 3 cycles; return data 0xA000..0xA003 -> mem_address steps 0x0120..0x0123; then re-request 0x0123 -> cache_miss = 0, cache_line = {0x0123, 1, 0xA003}.
- Sequential hits: after the fill, request 0x0120, 0x0121, 0x0122 on consecutive cycles -> three consecutive hits returning 0xA000, 0xA001, 0xA002 one cycle after each request.
- Conflict miss: after the 0x0120 fill, request 0x0523 (same index 0x23, tag 0x05) -> cache_miss = 1 and refill at 0x0520; then 0x0123 misses again.
- Invalidate mid-fill: pulse invalidate on the 2nd data word -> burst completes all 4 words, then 256 flush cycles; then 0x0123 misses.
- Wrap edge: request 0x7FFF -> mem_address = 0x7FFC..0x7FFF, no access at 0x0000; then 0x7FFF hits.

Source files
------------

// File: rtl/cpu_instruction_cache_pkg.sv
// Shared definitions for the instruction cache: cache_line field layout and FSM state encodings.
package cpu_instruction_cache_pkg;

    localparam int INS_BITS      = 16;

    localparam int LINE_ADDR_MSB = 31;
    localparam int LINE_ADDR_LSB = 17;
    localparam int LINE_VALID    = 16;
    localparam int LINE_INS_MSB  = 15;
    localparam int LINE_INS_LSB  = 0;

    localparam logic [1:0] ST_FLUSH   = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_REQUEST = 2'd2;
    localparam logic [1:0] ST_FILL    = 2'd3;

endpackage

// File: rtl/cpu_instruction_cache_ram.sv
// Tag/data store: simple dual-port RAM, 1-cycle synchronous read, one write port, no reset.
// A read and write to the same index in one cycle returns the old contents.
module cpu_instruction_cache_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 24
) (
    input  logic                 CLK,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cpu_instruction_cache.sv
// Direct-mapped instruction cache, 1-cycle hit latency; cache_miss refers to last cycle's address.
// On a miss it holds cache_miss high and fetches an aligned burst; the memory side throttles via grant/data-valid.
module cpu_instruction_cache
    import cpu_instruction_cache_pkg::*;
#(
    parameter int INDEX_BITS      = 8,
    parameter int ADDRESS_BITS    = 15,
    parameter int FILL_WORDS_LOG2 = 2
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [ADDRESS_BITS-1:0] cache_request_address,
    output logic [31:0]             cache_line,
    output logic                    cache_miss,
    input  logic                    invalidate,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic                    mem_rd_req,
    input  logic                    mem_rd_ready,
    input  logic [INS_BITS-1:0]     mem_data,
    input  logic                    mem_data_valid
);

    localparam int TAG_BITS   = ADDRESS_BITS - INDEX_BITS;
    localparam int ENTRY_BITS = 1 + TAG_BITS + INS_BITS;
    localparam int BLOCK_BITS = ADDRESS_BITS - FILL_WORDS_LOG2;
    localparam logic [INDEX_BITS-1:0]      LAST_INDEX = '1;
    localparam logic [FILL_WORDS_LOG2-1:0] LAST_WORD  = '1;

    logic [1:0]                 state;
    logic [INDEX_BITS-1:0]      flush_cnt;
    logic [FILL_WORDS_LOG2-1:0] word_cnt;
    logic [BLOCK_BITS-1:0]      fill_block;
    logic                       inv_pend;
    logic                       settle;
    logic [ADDRESS_BITS-1:0]    addr_r;
    logic [ADDRESS_BITS-1:0]    fill_addr;

    logic [ENTRY_BITS-1:0]      rd_entry;
    logic [ENTRY_BITS-1:0]      wr_entry;
    logic [INDEX_BITS-1:0]      wr_index;
    logic                       wr_en;

    logic                       entry_valid;
    logic [TAG_BITS-1:0]        entry_tag;
    logic [INS_BITS-1:0]        entry_data;
    logic                       hit;

    assign {entry_valid, entry_tag, entry_data} = rd_entry;

    // The fill address is the aligned block with the word counter in the low bits, so it never carries out.
    assign fill_addr = {fill_block, word_cnt};

    // The first idle cycle after a fill or flush sees a RAM read issued alongside the last write, so it is never trusted.
    assign hit = (state == ST_IDLE) && !settle && entry_valid
                 && (entry_tag == addr_r[ADDRESS_BITS-1:INDEX_BITS]);
    assign cache_miss = !hit;

    assign mem_rd_req  = (state == ST_REQUEST) || (state == ST_FILL);
    assign mem_address = fill_addr;

    always_comb begin
        cache_line = '0;
        if (state != ST_FLUSH) begin
            cache_line[LINE_ADDR_MSB:LINE_ADDR_LSB] = addr_r;
            cache_line[LINE_VALID]                  = entry_valid;
            cache_line[LINE_INS_MSB:LINE_INS_LSB]   = entry_data;
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_index = fill_addr[INDEX_BITS-1:0];
        wr_entry = {1'b1, fill_addr[ADDRESS_BITS-1:INDEX_BITS], mem_data};
        if (state == ST_FLUSH) begin
            wr_en    = 1'b1;
            wr_index = flush_cnt;
            wr_entry = '0;
        end else if (state == ST_FILL) begin
            wr_en = mem_data_valid;
        end
    end

    cpu_instruction_cache_ram #(
        .ADDR_BITS (INDEX_BITS),
        .DATA_BITS (ENTRY_BITS)
    ) u_ram (
        .CLK     (CLK),
        .rd_addr (cache_request_address[INDEX_BITS-1:0]),
        .rd_data (rd_entry),
        .wr_en   (wr_en),
        .wr_addr (wr_index),
        .wr_data (wr_entry)
    );

    always_ff @(posedge CLK) begin
        addr_r <= cache_request_address;
        if (!RSTb) begin
            state      <= ST_FLUSH;
            flush_cnt  <= '0;
            word_cnt   <= '0;
            fill_block <= '0;
            inv_pend   <= 1'b0;
            settle     <= 1'b0;
            addr_r     <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if (invalidate) begin
                        flush_cnt <= '0;
                    end else if (flush_cnt == LAST_INDEX) begin
                        state  <= ST_IDLE;
                        settle <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + INDEX_BITS'(1);
                    end
                end
                ST_IDLE: begin
                    settle <= 1'b0;
                    if (invalidate) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else if (!settle && !hit) begin
                        fill_block <= addr_r[ADDRESS_BITS-1:FILL_WORDS_LOG2];
                        word_cnt   <= '0;
                        state      <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (invalidate) begin
                        inv_pend <= 1'b1;
                    end
                    if (mem_rd_ready) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // A flush request waits for the burst to finish; the arbiter cannot be abandoned mid-burst.
                    if (invalidate) begin
                        inv_pend <= 1'b1;
                    end
                    if (mem_data_valid) begin
                        word_cnt <= word_cnt + FILL_WORDS_LOG2'(1);
                        if (word_cnt == LAST_WORD) begin
                            if (inv_pend || invalidate) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= '0;
                                inv_pend  <= 1'b0;
                            end else begin
                                state  <= ST_IDLE;
                                settle <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= ST_FLUSH;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_instruction_cache.sv
// Scoreboard bench for cpu_instruction_cache: stimulus queues expected responses, monitors compare on DUT activity.
module tb_cpu_instruction_cache;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic [14:0] cache_request_address;
    logic [31:0] cache_line;
    logic        cache_miss;
    logic        invalidate;
    logic [14:0] mem_address;
    logic        mem_rd_req;
    logic        mem_rd_ready;
    logic [15:0] mem_data;
    logic        mem_data_valid;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        miss;
        logic [31:0] line;
    } resp_t;

    resp_t       resp_q[$];
    logic [14:0] fill_q[$];
    logic [14:0] req_q[$];
    resp_t       exp_resp;
    logic [14:0] exp_addr;

    logic probe    = 1'b0;
    logic probe_d  = 1'b0;
    logic req_prev = 1'b0;

    always #5 CLK = ~CLK;

    cpu_instruction_cache dut (
        .CLK                   (CLK),
        .RSTb                  (RSTb),
        .cache_request_address (cache_request_address),
        .cache_line            (cache_line),
        .cache_miss            (cache_miss),
        .invalidate            (invalidate),
        .mem_address           (mem_address),
        .mem_rd_req            (mem_rd_req),
        .mem_rd_ready          (mem_rd_ready),
        .mem_data              (mem_data),
        .mem_data_valid        (mem_data_valid)
    );

    always @(posedge CLK) probe_d <= probe;

    // Response monitor: a probed request is answered in the following cycle.
    always @(negedge CLK) begin
        if (probe_d) begin
            tests++;
            if (resp_q.size() == 0) begin
                fails++;
                $display("FAIL resp: response with empty expectation queue (miss=%0d line=%h)", cache_miss, cache_line);
            end else begin
                exp_resp = resp_q.pop_front();
                if (exp_resp.miss) begin
                    if (cache_miss !== 1'b1 || cache_line[31:17] !== exp_resp.line[31:17]) begin
                        fails++;
                        $display("FAIL resp_miss: got miss=%0d addr=%h, want miss=1 addr=%h",
                                 cache_miss, cache_line[31:17], exp_resp.line[31:17]);
                    end
                end else if (cache_miss !== 1'b0 || cache_line !== exp_resp.line) begin
                    fails++;
                    $display("FAIL resp_hit: got miss=%0d line=%h, want miss=0 line=%h",
                             cache_miss, cache_line, exp_resp.line);
                end
            end
        end
    end

    // Memory-side monitor: burst start address and every fill word address.
    always @(negedge CLK) begin
        if (mem_rd_req && !req_prev) begin
            tests++;
            if (req_q.size() == 0) begin
                fails++;
                $display("FAIL req_start: unexpected fill request at %h", mem_address);
            end else begin
                exp_addr = req_q.pop_front();
                if (mem_address !== exp_addr) begin
                    fails++;
                    $display("FAIL req_start: got mem_address=%h want %h", mem_address, exp_addr);
                end
            end
        end
        if (mem_rd_req && mem_data_valid) begin
            tests++;
            if (fill_q.size() == 0) begin
                fails++;
                $display("FAIL fill_addr: unexpected fill beat at %h", mem_address);
            end else begin
                exp_addr = fill_q.pop_front();
                if (mem_address !== exp_addr) begin
                    fails++;
                    $display("FAIL fill_addr: got mem_address=%h want %h", mem_address, exp_addr);
                end
            end
        end
        req_prev <= mem_rd_req;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic probe_req(input logic [14:0] a, input logic miss, input logic [15:0] ins);
        cache_request_address = a;
        probe = 1'b1;
        resp_q.push_back({miss, a, ~miss, ins});
        @(posedge CLK);
        #1 probe = 1'b0;
    endtask

    // Memory responder: grant after 'delay' cycles, four beats with a one-cycle gap before the third.
    task automatic serve(input logic [14:0] blk, input logic [15:0] base, input int delay, input int inv_beat);
        repeat (delay) @(posedge CLK);
        #1 mem_rd_ready = 1'b1;
        @(posedge CLK);
        #1 mem_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(posedge CLK);
                #1;
            end
            fill_q.push_back(blk + 15'(i));
            mem_data       = base + 16'(i);
            mem_data_valid = 1'b1;
            invalidate     = (i == inv_beat);
            @(posedge CLK);
            #1 mem_data_valid = 1'b0;
            invalidate = 1'b0;
        end
        @(negedge CLK);
        check("req_drop", 32'(mem_rd_req), 32'd0);
    endtask

    task automatic fetch(input logic [14:0] a, input logic [15:0] base, input int delay, input int inv_beat);
        int n = 0;
        logic [14:0] blk;
        blk = {a[14:2], 2'b00};
        req_q.push_back(blk);
        probe_req(a, 1'b1, 16'h0000);
        while (!mem_rd_req && n < 600) begin
            @(negedge CLK);
            n++;
        end
        if (!mem_rd_req) begin
            tests++;
            fails++;
            $display("FAIL fill_start: no mem_rd_req within %0d cycles for %h", n, a);
        end else begin
            serve(blk, base, delay, inv_beat);
            if (inv_beat < 0) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        int n;
        RSTb                  = 1'b0;
        cache_request_address = 15'h0000;
        invalidate            = 1'b0;
        mem_rd_ready          = 1'b0;
        mem_data              = 16'h0000;
        mem_data_valid        = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_line", cache_line, 32'h0);
        check("reset_miss", 32'(cache_miss), 32'd1);
        check("reset_req", 32'(mem_rd_req), 32'd0);
        RSTb = 1'b1;

        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            check("boot_flush", {30'd0, cache_miss, mem_rd_req}, 32'b10);
        end

        // First request after the boot flush misses at 0x0000.
        fetch(15'h0000, 16'h1000, 2, -1);
        probe_req(15'h0000, 1'b0, 16'h1000);

        // Cold miss, then hit on the same word and sequential hits in the block.
        fetch(15'h0123, 16'hA000, 3, -1);
        probe_req(15'h0123, 1'b0, 16'hA003);
        probe_req(15'h0120, 1'b0, 16'hA000);
        probe_req(15'h0121, 1'b0, 16'hA001);
        probe_req(15'h0122, 1'b0, 16'hA002);

        // Conflict on index 0x23 with tag 0x05.
        fetch(15'h0523, 16'hB000, 1, -1);
        probe_req(15'h0523, 1'b0, 16'hB003);
        probe_req(15'h0001, 1'b0, 16'h1001);

        // 0x0123 misses again; invalidate on the second beat defers a flush until the burst ends.
        fetch(15'h0123, 16'hD000, 2, 1);
        for (int i = 0; i < 255; i++) begin
            @(negedge CLK);
            check("inv_flush", {30'd0, cache_miss, mem_rd_req}, 32'b10);
        end
        fetch(15'h0123, 16'hE000, 1, -1);
        probe_req(15'h0121, 1'b0, 16'hE001);
        probe_req(15'h0123, 1'b0, 16'hE003);

        // Top-of-memory block stays within 0x7FFC..0x7FFF.
        fetch(15'h7FFF, 16'hC000, 2, -1);
        probe_req(15'h7FFF, 1'b0, 16'hC003);
        probe_req(15'h7FFC, 1'b0, 16'hC000);
        probe_req(15'h7FFF, 1'b0, 16'hC003);

        // Invalidate in idle, then again 100 cycles into the flush: the flush restarts from entry 0.
        invalidate = 1'b1;
        @(posedge CLK);
        #1 invalidate = 1'b0;
        repeat (99) @(posedge CLK);
        #1 invalidate = 1'b1;
        @(posedge CLK);
        #1 invalidate = 1'b0;
        req_q.push_back(15'h7FFC);
        n = 0;
        while (!mem_rd_req && n < 600) begin
            @(negedge CLK);
            n++;
        end
        check("flush_restart_len", 32'(n), 32'd259);
        if (mem_rd_req) begin
            serve(15'h7FFC, 16'hF000, 1, -1);
            @(posedge CLK);
            #1;
            probe_req(15'h7FFE, 1'b0, 16'hF002);
        end

        @(negedge CLK);
        #1;
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);
        check("fill_q_empty", 32'(fill_q.size()), 32'd0);
        check("req_q_empty", 32'(req_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (%0d tests, %0d failed)", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
